// File: rtl/uart_rx_16x_if.sv
// rtl/uart_rx_16x_if.sv - tick/serial inputs and byte/status outputs of the 16x UART receiver
interface uart_rx_16x_if #(
    parameter int DATA_BITS = 8
);
    logic                 iB_Tick;
    logic                 iRx;
    logic [DATA_BITS-1:0] oRx_Data;
    logic                 oRx_Done;
    logic                 oFrame_Err;
    logic                 oRx_Busy;

    modport master (
        output iB_Tick, iRx,
        input  oRx_Data, oRx_Done, oFrame_Err, oRx_Busy
    );

    modport slave (
        input  iB_Tick, iRx,
        output oRx_Data, oRx_Done, oFrame_Err, oRx_Busy
    );
endinterface

// File: rtl/uart_rx_16x.sv
// rtl/uart_rx_16x.sv - 8N1 UART receiver, 16x oversampled, 3-sample majority vote per bit
module uart_rx_16x #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int VOTE_POS   = 7
) (
    input  logic          iClk,
    input  logic          iRst_n,
    uart_rx_16x_if.slave  bus
);
    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] T_V0   = CW'(VOTE_POS);
    localparam logic [CW-1:0] T_V1   = CW'(VOTE_POS + 1);
    localparam logic [CW-1:0] T_V2   = CW'(VOTE_POS + 2);
    localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t               state;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 frame_err;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 v0;
    logic                 v1;
    logic                 maj;

    // Sync flops reset high so a reset never looks like a start bit.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.iRx;
            rx_s    <= rx_meta;
        end
    end

    // Third vote sample is the live rx_s on the decision tick.
    assign maj = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            v0        <= 1'b0;
            v1        <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            if (bus.iB_Tick) begin
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (!rx_s) state <= START;
                    end
                    WAIT_HIGH: begin
                        tick_cnt <= '0;
                        if (rx_s) state <= IDLE;
                    end
                    default: begin
                        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
                        if (tick_cnt == T_V0) v0 <= rx_s;
                        if (tick_cnt == T_V1) v1 <= rx_s;
                        if (tick_cnt == T_V2) begin
                            case (state)
                                START: begin
                                    if (maj) begin
                                        state    <= IDLE;
                                        tick_cnt <= '0;
                                    end
                                end
                                DATA: shift <= {maj, shift[DATA_BITS-1:1]};
                                STOP: begin
                                    // Leave STOP early to gain resync margin for the next start bit.
                                    tick_cnt <= '0;
                                    if (maj) begin
                                        rx_data <= shift;
                                        rx_done <= 1'b1;
                                        state   <= IDLE;
                                    end else begin
                                        frame_err <= 1'b1;
                                        state     <= WAIT_HIGH;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        if (tick_cnt == T_LAST) begin
                            if (state == START) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else if (state == DATA) begin
                                if (bit_cnt == B_LAST) state <= STOP;
                                else bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.oRx_Data   = rx_data;
    assign bus.oRx_Done   = rx_done;
    assign bus.oFrame_Err = frame_err;
    assign bus.oRx_Busy   = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_16x.sv
// tb/tb_uart_rx_16x.sv - directed table-driven bench for uart_rx_16x
module tb_uart_rx_16x;
    logic iClk = 1'b0;
    logic iRst_n = 1'b0;
    logic [3:0] div = 4'd0;

    always #5 iClk = ~iClk;

    uart_rx_16x_if #(.DATA_BITS(8)) bus ();

    uart_rx_16x #(.DATA_BITS(8), .OVERSAMPLE(16), .VOTE_POS(7)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus.slave)
    );

    initial bus.iB_Tick = 1'b0;
    always @(posedge iClk) begin
        div         <= div + 4'd1;
        bus.iB_Tick <= (div == 4'd14);
    end

    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    always @(negedge iClk) begin
        if (bus.oRx_Done) done_cnt++;
        if (bus.oFrame_Err) err_cnt++;
        if (bus.oRx_Done && bus.oFrame_Err) both_cnt++;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_wait();
        int n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while (!bus.iB_Tick && n < 64);
        if (!bus.iB_Tick) begin
            tests++;
            fails++;
            $display("FAIL tick_timeout: got no tick expected tick within 64 clocks");
        end
        @(posedge iClk);
        #1;
    endtask

    task automatic hold(input logic level, input int n);
        for (int i = 0; i < n; i++) begin
            bus.iRx = level;
            tick_wait();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch,
                              output bit busy_low, output logic busy_stop);
        busy_low  = 1'b0;
        busy_stop = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.iRx = 1'b0;
            tick_wait();
            if (!bus.oRx_Busy) busy_low = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 16; k++) begin
                bus.iRx = (glitch && k == 8) ? ~d[b] : d[b];
                tick_wait();
                if (!bus.oRx_Busy) busy_low = 1'b1;
            end
        end
        for (int k = 0; k < 16; k++) begin
            bus.iRx = stop;
            tick_wait();
            if (k == 12) busy_stop = bus.oRx_Busy;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        bit         glitch;
        logic [7:0] exp_data;
        int         exp_done;
        int         exp_err;
        logic       exp_busy_stop;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int d0, e0;
        bit busy_low;
        logic busy_stop;
        logic [7:0] m;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1, 0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1, 0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1, 0, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1, 0, 1'b0};
        vecs[4] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1, 0, 1'b0};

        bus.iRx = 1'b1;
        iRst_n  = 1'b0;
        repeat (5) @(posedge iClk);
        #1;
        check("rst_data", bus.oRx_Data, 8'h00);
        check("rst_done", bus.oRx_Done, 1'b0);
        check("rst_err", bus.oFrame_Err, 1'b0);
        check("rst_busy", bus.oRx_Busy, 1'b0);
        @(negedge iClk);
        iRst_n = 1'b1;
        hold(1'b1, 4);

        // Frames are sent back to back with no idle gap between them.
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].glitch, busy_low, busy_stop);
            check($sformatf("v%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("v%0d_data", i), bus.oRx_Data, vecs[i].exp_data);
            check($sformatf("v%0d_busy_low", i), busy_low, 1'b0);
            check($sformatf("v%0d_busy_stop", i), busy_stop, vecs[i].exp_busy_stop);
        end
        hold(1'b1, 4);

        // False start: 3 low ticks, vote sees high and returns to IDLE.
        d0 = done_cnt;
        e0 = err_cnt;
        hold(1'b0, 3);
        hold(1'b1, 1);
        check("glitch_busy_mid", bus.oRx_Busy, 1'b1);
        hold(1'b1, 7);
        check("glitch_busy_end", bus.oRx_Busy, 1'b0);
        hold(1'b1, 8);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_err", err_cnt - e0, 0);

        // Break: bad stop bit, then line stuck low.
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b0, busy_low, busy_stop);
        hold(1'b0, 40);
        check("brk_err", err_cnt - e0, 1);
        check("brk_done", done_cnt - d0, 0);
        check("brk_data", bus.oRx_Data, 8'hC3);
        check("brk_busy_low", bus.oRx_Busy, 1'b1);
        hold(1'b1, 2);
        check("brk_busy_high", bus.oRx_Busy, 1'b0);
        hold(1'b1, 4);

        // Reset in the middle of data bit 4 of 0x81.
        d0 = done_cnt;
        e0 = err_cnt;
        m  = 8'h81;
        hold(1'b0, 16);
        for (int b = 0; b < 4; b++) hold(m[b], 16);
        hold(m[4], 8);
        #3;
        iRst_n = 1'b0;
        #1;
        check("mid_rst_data", bus.oRx_Data, 8'h00);
        check("mid_rst_done", bus.oRx_Done, 1'b0);
        check("mid_rst_err", bus.oFrame_Err, 1'b0);
        check("mid_rst_busy", bus.oRx_Busy, 1'b0);
        bus.iRx = 1'b1;
        repeat (10) @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        hold(1'b1, 20);
        check("abort_done", done_cnt - d0, 0);
        check("abort_err", err_cnt - e0, 0);
        send_frame(8'h42, 1'b1, 1'b0, busy_low, busy_stop);
        hold(1'b1, 2);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_data", bus.oRx_Data, 8'h42);
        check("post_rst_busy_low", busy_low, 1'b0);

        check("done_err_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
